// File: rtl/burst_buffer.sv
// burst_buffer: serial-to-parallel burst collector.
// Drops the first INITIAL_LATENCY accepted samples after reset, then packs
// every M accepted samples into data_out and pulses out_ready once per burst.
// Optional macro BURST_BUFFER_CNT_EN adds a 16-bit completed-burst counter.
module burst_buffer #(
    parameter int unsigned INITIAL_LATENCY = 3,
    parameter int unsigned M               = 5,
    parameter int unsigned PRECISION       = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ce,
    input  logic [PRECISION-1:0]          data_in,
    output logic [M-1:0][PRECISION-1:0]   data_out,
    output logic                          out_ready
`ifdef BURST_BUFFER_CNT_EN
    ,
    output logic [15:0]                   burst_cnt
`endif
);

    localparam int unsigned CNT_MAX  = (INITIAL_LATENCY > M) ? INITIAL_LATENCY : M;
    localparam int unsigned CNT_W_RAW = $clog2(CNT_MAX + 1);
    localparam int unsigned CNT_W    = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam int unsigned LAT_LAST_I = (INITIAL_LATENCY == 0) ? 0 : INITIAL_LATENCY - 1;
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(LAT_LAST_I);
    localparam logic [CNT_W-1:0] BST_LAST = CNT_W'(M - 1);

    typedef enum logic [0:0] {
        ST_LATENCY = 1'b0,
        ST_FILL    = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (INITIAL_LATENCY == 0) ? ST_FILL : ST_LATENCY;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              lat_cnt_q, lat_cnt_d;
    logic [CNT_W-1:0]              bst_cnt_q, bst_cnt_d;
    logic [M-1:0][PRECISION-1:0]   stage_q, stage_d;
    logic [M-1:0][PRECISION-1:0]   data_out_q, data_out_d;
    logic                          out_ready_q, out_ready_d;
`ifdef BURST_BUFFER_CNT_EN
    logic [15:0]                   burst_cnt_q, burst_cnt_d;
`endif

    // Next-state: discard fill samples, then stage samples and publish each full burst.
    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        bst_cnt_d   = bst_cnt_q;
        stage_d     = stage_q;
        data_out_d  = data_out_q;
        out_ready_d = 1'b0;
`ifdef BURST_BUFFER_CNT_EN
        burst_cnt_d = burst_cnt_q;
`endif
        if (ce) begin
            case (state_q)
                ST_LATENCY: begin
                    lat_cnt_d = lat_cnt_q + CNT_W'(1);
                    if (lat_cnt_q == LAT_LAST) begin
                        state_d = ST_FILL;
                    end
                end
                ST_FILL: begin
                    for (int k = 0; k < int'(M); k++) begin
                        if (bst_cnt_q == CNT_W'(k)) begin
                            stage_d[k] = data_in;
                        end
                    end
                    if (bst_cnt_q == BST_LAST) begin
                        data_out_d  = stage_d;
                        out_ready_d = 1'b1;
                        bst_cnt_d   = '0;
`ifdef BURST_BUFFER_CNT_EN
                        burst_cnt_d = burst_cnt_q + 16'd1;
`endif
                    end else begin
                        bst_cnt_d = bst_cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = RESET_STATE;
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RESET_STATE;
            lat_cnt_q   <= '0;
            bst_cnt_q   <= '0;
            stage_q     <= '0;
            data_out_q  <= '0;
            out_ready_q <= 1'b0;
`ifdef BURST_BUFFER_CNT_EN
            burst_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            bst_cnt_q   <= bst_cnt_d;
            stage_q     <= stage_d;
            data_out_q  <= data_out_d;
            out_ready_q <= out_ready_d;
`ifdef BURST_BUFFER_CNT_EN
            burst_cnt_q <= burst_cnt_d;
`endif
        end
    end

    assign data_out  = data_out_q;
    assign out_ready = out_ready_q;
`ifdef BURST_BUFFER_CNT_EN
    assign burst_cnt = burst_cnt_q;
`endif

endmodule

// File: tb/tb_burst_buffer.sv
// Self-checking bench for burst_buffer: default instance (3/5/5) plus an
// INITIAL_LATENCY=0, M=1 instance, both checked against a queue-based model.
module tb_burst_buffer;

    localparam int IL = 3;
    localparam int MM = 5;
    localparam int P  = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ce  = 1'b0;
    logic [P-1:0] data_in = '0;
    logic [MM-1:0][P-1:0] data_out;
    logic out_ready;

    logic ce1 = 1'b0;
    logic [P-1:0] data_in1 = '0;
    logic [0:0][P-1:0] data_out1;
    logic out_ready1;
    logic ce1_force = 1'b0;

`ifdef BURST_BUFFER_CNT_EN
    logic [15:0] burst_cnt;
    logic [15:0] burst_cnt1;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    burst_buffer #(.INITIAL_LATENCY(IL), .M(MM), .PRECISION(P)) dut (
        .clk(clk), .rst(rst), .ce(ce), .data_in(data_in),
        .data_out(data_out), .out_ready(out_ready)
`ifdef BURST_BUFFER_CNT_EN
        , .burst_cnt(burst_cnt)
`endif
    );

    burst_buffer #(.INITIAL_LATENCY(0), .M(1), .PRECISION(P)) dut1 (
        .clk(clk), .rst(rst), .ce(ce1), .data_in(data_in1),
        .data_out(data_out1), .out_ready(out_ready1)
`ifdef BURST_BUFFER_CNT_EN
        , .burst_cnt(burst_cnt1)
`endif
    );

    // Reference model: counts accepted samples, queues burst members.
    int acc = 0;
    int q[$];
    logic [MM-1:0][P-1:0] exp_data = '0;
    logic exp_rdy = 1'b0;
    int exp_cnt = 0;
    logic [P-1:0] exp1_data = '0;
    logic exp1_rdy = 1'b0;
    int exp1_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        acc = 0;
        q.delete();
        exp_data = '0;
        exp_rdy = 1'b0;
        exp_cnt = 0;
        exp1_data = '0;
        exp1_rdy = 1'b0;
        exp1_cnt = 0;
    endtask

    task automatic model_update(input logic c, input logic [P-1:0] d,
                                input logic c1, input logic [P-1:0] d1);
        exp_rdy = 1'b0;
        if (c) begin
            if (acc < IL) begin
                acc++;
            end else begin
                q.push_back(int'(d));
                if (q.size() == MM) begin
                    for (int k = 0; k < MM; k++) exp_data[k] = P'(q[k]);
                    q.delete();
                    exp_rdy = 1'b1;
                    exp_cnt++;
                end
            end
        end
        exp1_rdy = c1;
        if (c1) begin
            exp1_data = d1;
            exp1_cnt++;
        end
    endtask

    // One clock: apply inputs, let the edge happen, advance the model.
    task automatic step(input logic c, input logic [P-1:0] d);
        logic c1;
        logic [P-1:0] d1;
        c1 = ce1_force ? 1'b1 : 1'($urandom_range(1, 0));
        d1 = P'($urandom);
        ce = c; data_in = d; ce1 = c1; data_in1 = d1;
        @(posedge clk);
        #1;
        model_update(c, d, c1, d1);
    endtask

    task automatic feed(input int a, input int b, input int c, input int d, input int e);
        step(1'b1, P'(a)); step(1'b1, P'(b)); step(1'b1, P'(c));
        step(1'b1, P'(d)); step(1'b1, P'(e));
    endtask

    // Compare DUT outputs to the model on every falling edge.
    always @(negedge clk) begin
        chk("data_out", 64'(data_out), 64'(exp_data));
        chk("out_ready", 64'(out_ready), 64'(exp_rdy));
        chk("m1_data_out", 64'(data_out1[0]), 64'(exp1_data));
        chk("m1_out_ready", 64'(out_ready1), 64'(exp1_rdy));
`ifdef BURST_BUFFER_CNT_EN
        chk("burst_cnt", 64'(burst_cnt), 64'(16'(exp_cnt)));
        chk("m1_burst_cnt", 64'(burst_cnt1), 64'(16'(exp1_cnt)));
`endif
    end

    initial begin
        model_reset();
        #3;
        chk("reset_data_out", 64'(data_out), 64'd0);
        chk("reset_out_ready", 64'(out_ready), 64'd0);
        #9 rst = 1'b1;

        // Fill samples are discarded, then first burst.
        step(1'b1, 5'd1); step(1'b1, 5'd2); step(1'b1, 5'd3);
        feed(10, 11, 12, 13, 14);
        chk("b1_ready", 64'(out_ready), 64'd1);
        chk("b1_e0", 64'(data_out[0]), 64'd10);
        chk("b1_e4", 64'(data_out[4]), 64'd14);
`ifdef BURST_BUFFER_CNT_EN
        chk("b1_cnt", 64'(burst_cnt), 64'd1);
`endif

        // ce gap mid-burst: 31 must not be captured.
        step(1'b1, 5'd20); step(1'b1, 5'd21);
        chk("gap_ready_clear", 64'(out_ready), 64'd0);
        repeat (3) step(1'b0, 5'd31);
        chk("gap_hold_e0", 64'(data_out[0]), 64'd10);
        step(1'b1, 5'd22); step(1'b1, 5'd23); step(1'b1, 5'd24);
        chk("b2_ready", 64'(out_ready), 64'd1);
        chk("b2_e2", 64'(data_out[2]), 64'd22);
        chk("b2_e4", 64'(data_out[4]), 64'd24);

        feed(14, 12, 25, 23, 14);
        chk("b3_e2", 64'(data_out[2]), 64'd25);
        feed(4, 1, 7, 3, 2);
        chk("b4_e0", 64'(data_out[0]), 64'd4);
        chk("b4_e4", 64'(data_out[4]), 64'd2);
`ifdef BURST_BUFFER_CNT_EN
        chk("b4_cnt", 64'(burst_cnt), 64'd4);
`endif

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(3, 0) != 0), P'($urandom));
        end

        // Asynchronous reset in the middle of a partial burst.
        step(1'b1, 5'd9); step(1'b1, 5'd9);
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("async_data_out", 64'(data_out), 64'd0);
        chk("async_out_ready", 64'(out_ready), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        // Latency phase repeats after reset release.
        step(1'b1, 5'd5); step(1'b1, 5'd6); step(1'b1, 5'd7);
        feed(8, 9, 10, 11, 12);
        chk("rr_ready", 64'(out_ready), 64'd1);
        chk("rr_e0", 64'(data_out[0]), 64'd8);
        chk("rr_e4", 64'(data_out[4]), 64'd12);

        // M=1 instance with ce held high: out_ready stays asserted.
        ce1_force = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1'($urandom_range(1, 0)), P'($urandom));
            chk("m1_cont_ready", 64'(out_ready1), 64'd1);
        end
        ce1_force = 1'b0;

        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(3, 0) != 0), P'($urandom));
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
